// File: rtl/transposed_sample_buffer.sv
// N x N signed sample block buffer: rows are written in, then drained one vector
// per handshake either column-wise (transpose) or row-wise (bypass).
module transposed_sample_buffer #(
  parameter int SAMPLE_W = 11,
  parameter int N        = 8,
  parameter int CNT_W    = $clog2(N)
) (
  input  logic                  CLK,
  input  logic                  RST_ASYNC,
  input  logic                  CLEAR,
  input  logic                  MODE,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [N*SAMPLE_W-1:0] DATA_IN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [N*SAMPLE_W-1:0] DATA_OUT,
  output logic                  OUT_LAST,
  output logic                  BLOCK_DONE
);

  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]            rd_cnt_q, rd_cnt_d;
  logic                        mode_q, mode_d;
  logic                        done_q, done_d;
  logic                        wr_en;
  logic signed [SAMPLE_W-1:0]  arr_q [N][N];

  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  // CLEAR overrides any handshake in the same cycle, so a row offered with it is dropped.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    if (CLEAR) begin
      state_d  = FILL;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (IN_VALID) begin
            if (wr_cnt_q == '0) mode_d = MODE;
            if (wr_cnt_q == LAST_IDX) begin
              wr_cnt_d = '0;
              state_d  = DRAIN;
            end else begin
              wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (OUT_READY) begin
            if (rd_cnt_q == LAST_IDX) begin
              rd_cnt_d = '0;
              state_d  = FILL;
              done_d   = 1'b1;
            end else begin
              rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  assign wr_en = !CLEAR && (state_q == FILL) && IN_VALID;

  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          arr_q[r][c] <= '0;
    end else if (wr_en) begin
      for (int c = 0; c < N; c++)
        arr_q[wr_cnt_q][c] <= DATA_IN[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Output is a pure mux of registered state, so no input reaches an output combinationally.
  always_comb begin
    DATA_OUT = '0;
    for (int k = 0; k < N; k++) begin
      if (mode_q) DATA_OUT[k*SAMPLE_W +: SAMPLE_W] = arr_q[rd_cnt_q][k];
      else        DATA_OUT[k*SAMPLE_W +: SAMPLE_W] = arr_q[k][rd_cnt_q];
    end
  end

  assign IN_READY   = (state_q == FILL);
  assign OUT_VALID  = (state_q == DRAIN);
  assign OUT_LAST   = (state_q == DRAIN) && (rd_cnt_q == LAST_IDX);
  assign BLOCK_DONE = done_q;

endmodule
